// File: rtl/clk_disp_pkg.sv
// Shared definitions for the time-of-day display scanner: digit count,
// slot index type, slot-to-field map, active-low 7-segment codes and a
// binary-to-BCD helper.
package clk_disp_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int DIDX_W     = 3;

   typedef logic [DIDX_W-1:0] didx_t;

   // Slot-to-field mapping: which digit of which field each slot shows
   localparam didx_t SLOT_SEC_ONES = 3'd0;
   localparam didx_t SLOT_SEC_TENS = 3'd1;
   localparam didx_t SLOT_MIN_ONES = 3'd2;
   localparam didx_t SLOT_MIN_TENS = 3'd3;
   localparam didx_t SLOT_HR_ONES  = 3'd4;
   localparam didx_t SLOT_HR_TENS  = 3'd5;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Split a binary value into {tens, ones}; out-of-range values are kept
   // numeric rather than clamped (63 -> 6,3; 15 -> 1,5)
   function automatic logic [7:0] toBcd(input logic [6:0] value);
      return {4'(value / 7'd10), 4'(value % 7'd10)};
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment code. Anything above 9 is blanked.
module seg7_decode
   import clk_disp_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   // Pure lookup; default covers the non-decimal codes 10..15
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment driver for the 12-hour clock.
// Snapshots seconds/minutes/hours once per frame so digits never tear,
// scans slots 0..5 (sec ones .. hour tens) with a one-cycle blanking gap
// at the start of each slot, and blinks the colon dots with seconds[0].
// Optional build macro CLK_DISP_LZ_BLANK_EN suppresses a leading-zero
// hours tens digit; without it slot 5 always shows its digit.
module clock_display_scan
   import clk_disp_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [5:0]            seconds,
   input  logic [5:0]            minutes,
   input  logic [3:0]            hours,
   output logic [NUM_DIGITS-1:0] digit_en_n,
   output logic [6:0]            seg_n,
   output logic                  dp_n,
   output logic                  frame_start
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0]         r_pcnt;
   didx_t                 r_didx;
   logic                  r_prime;
   logic [5:0]            r_snapSec;
   logic [5:0]            r_snapMin;
   logic [3:0]            r_snapHr;

   logic                  w_lastTick;
   logic                  w_load;
   logic [7:0]            w_secBcd;
   logic [7:0]            w_minBcd;
   logic [7:0]            w_hrBcd;
   logic [3:0]            w_bcd;
   logic [6:0]            w_seg;
   logic [NUM_DIGITS-1:0] w_enNext;
   logic [6:0]            w_segNext;
   logic                  w_dpNext;

   assign w_lastTick = (r_pcnt == PW'(SCAN_DIV - 1));
   assign w_load     = r_prime || (w_lastTick && (r_didx == SLOT_HR_TENS));

   assign w_secBcd = toBcd({1'b0, r_snapSec});
   assign w_minBcd = toBcd({1'b0, r_snapMin});
   assign w_hrBcd  = toBcd({3'b000, r_snapHr});

   // Prescaler wraps every SCAN_DIV cycles and steps the slot index 0..5
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pcnt <= '0;
         r_didx <= SLOT_SEC_ONES;
      end else if (w_lastTick) begin
         r_pcnt <= '0;
         r_didx <= (r_didx == SLOT_HR_TENS) ? SLOT_SEC_ONES : didx_t'(r_didx + 3'd1);
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

   // Snapshot the time on the first edge out of reset and at every frame wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prime   <= 1'b1;
         r_snapSec <= '0;
         r_snapMin <= '0;
         r_snapHr  <= '0;
      end else if (w_load) begin
         r_prime   <= 1'b0;
         r_snapSec <= seconds;
         r_snapMin <= minutes;
         r_snapHr  <= hours;
      end
   end

   // Pick the BCD digit belonging to the slot currently being scanned
   always_comb begin
      w_bcd = 4'd0;
      case (r_didx)
         SLOT_SEC_ONES: w_bcd = w_secBcd[3:0];
         SLOT_SEC_TENS: w_bcd = w_secBcd[7:4];
         SLOT_MIN_ONES: w_bcd = w_minBcd[3:0];
         SLOT_MIN_TENS: w_bcd = w_minBcd[7:4];
         SLOT_HR_ONES:  w_bcd = w_hrBcd[3:0];
         SLOT_HR_TENS:  w_bcd = w_hrBcd[7:4];
         default:       w_bcd = 4'd0;
      endcase
   end

   seg7_decode u_decode (
      .i_bcd (w_bcd),
      .o_seg (w_seg)
   );

   // Next output image: blank on the first cycle of each slot, else drive it
   always_comb begin
      w_enNext  = '1;
      w_segNext = SEG_BLANK;
      w_dpNext  = 1'b1;
      if (r_pcnt != '0) begin
         w_enNext  = ~(NUM_DIGITS'(1) << r_didx);
         w_segNext = w_seg;
         w_dpNext  = ~(((r_didx == SLOT_MIN_ONES) || (r_didx == SLOT_HR_ONES)) && !r_snapSec[0]);
`ifdef CLK_DISP_LZ_BLANK_EN
         if ((r_didx == SLOT_HR_TENS) && (w_hrBcd[7:4] == 4'd0)) begin
            w_enNext  = '1;
            w_segNext = SEG_BLANK;
         end
`endif
      end
   end

   // Register every output; frame_start marks the slot-0 blanking cycle,
   // which is the first output cycle that follows each snapshot load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_en_n  <= '1;
         seg_n       <= SEG_BLANK;
         dp_n        <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         digit_en_n  <= w_enNext;
         seg_n       <= w_segNext;
         dp_n        <= w_dpNext;
         frame_start <= (r_pcnt == '0) && (r_didx == SLOT_SEC_ONES);
      end
   end

endmodule
